// File: rtl/instruction_memory_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Defaults here are the widths the loader is normally built with.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_BITS_SIZE   = 32;
    localparam int DEF_MEMORY_SIZE = 256;
    localparam int BYTES_PER_WORD  = DEF_BITS_SIZE / 8;
    localparam int BCNT_W          = $clog2(BYTES_PER_WORD + 1);

endpackage

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface instruction_memory_loader_if
    import loader_pkg::*;
#(
    parameter int BITS_SIZE = DEF_BITS_SIZE
) ();
    logic [7:0]           ByteIn;
    logic                 ByteValid;
    logic                 ByteReady;
    logic                 WriteEnable;
    logic [BITS_SIZE-1:0] WriteAddress;
    logic [BITS_SIZE-1:0] WriteData;

    modport master (
        input  ByteIn, ByteValid,
        output ByteReady, WriteEnable, WriteAddress, WriteData
    );

    modport slave (
        output ByteIn, ByteValid,
        input  ByteReady, WriteEnable, WriteAddress, WriteData
    );
endinterface

// File: rtl/instruction_memory_loader_word_packer.sv
// Big-endian byte shift register with byte counter.
// Latency: word_out updated the edge after each accepted byte.
// Backpressure: none inside; the caller gates shift_en with its ready.
module word_packer
    import loader_pkg::*;
#(
    parameter int BITS_SIZE = DEF_BITS_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [7:0]           byte_in,
    output logic [BITS_SIZE-1:0] word_out,
    output logic                 word_full
);
    localparam int BYTES = BITS_SIZE / 8;
    localparam int CNT_W = $clog2(BYTES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_out <= '0;
            cnt      <= '0;
        end else if (shift_en) begin
            word_out <= {word_out[BITS_SIZE-9:0], byte_in};
            cnt      <= cnt + 1'b1;
        end
    end

    // Flags the shift that completes the word, so the FSM can move to WRITE on the same edge.
    assign word_full = shift_en && (cnt == CNT_W'(BYTES - 1));

endmodule

// File: rtl/instruction_memory_loader.sv
// Packs a byte stream into words and writes them to instruction memory at 0..WordCount-1.
// Latency: write strobe the cycle after the last byte of a word; Done the cycle after the final write.
// Backpressure: ByteReady only in RECV; the source is held during WRITE/DONE/IDLE.
module instruction_memory_loader
    import loader_pkg::*;
#(
    parameter int BITS_SIZE   = DEF_BITS_SIZE,
    parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        Start,
    input  logic [BITS_SIZE-1:0]        WordCount,
    output logic                        Busy,
    output logic                        Done,
    output logic                        Error,
    instruction_memory_loader_if.master bus
);
    state_t               state;
    logic [BITS_SIZE-1:0] count_lat;
    logic                 start_ok;
    logic                 shift_en;
    logic                 clear;
    logic                 word_full;

    assign start_ok      = (state == IDLE) && Start && (WordCount != '0)
                           && (WordCount <= BITS_SIZE'(MEMORY_SIZE));
    assign bus.ByteReady = (state == RECV);
    assign shift_en      = bus.ByteValid && bus.ByteReady;
    assign clear         = start_ok || (state == WRITE);

    word_packer #(.BITS_SIZE(BITS_SIZE)) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .shift_en (shift_en),
        .byte_in  (bus.ByteIn),
        .word_out (bus.WriteData),
        .word_full(word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            count_lat        <= '0;
            bus.WriteEnable  <= 1'b0;
            bus.WriteAddress <= '0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            Error            <= 1'b0;
        end else begin
            bus.WriteEnable <= 1'b0;
            Done            <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (WordCount == '0) begin
                            Error <= 1'b0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end else if (WordCount > BITS_SIZE'(MEMORY_SIZE)) begin
                            Error <= 1'b1;
                        end else begin
                            count_lat        <= WordCount;
                            bus.WriteAddress <= '0;
                            Error            <= 1'b0;
                            Busy             <= 1'b1;
                            state            <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (word_full) begin
                        bus.WriteEnable <= 1'b1;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    // WriteAddress doubles as the word index, so it holds the last address in DONE.
                    if (bus.WriteAddress == count_lat - BITS_SIZE'(1)) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        bus.WriteAddress <= bus.WriteAddress + BITS_SIZE'(1);
                        state            <= RECV;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed table-driven bench for instruction_memory_loader plus multi-cycle corner sequences.
module tb_instruction_memory_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [31:0] WordCount;
    logic        Busy, Done, Error;

    instruction_memory_loader_if #(.BITS_SIZE(32)) bus ();

    instruction_memory_loader #(.BITS_SIZE(32), .MEMORY_SIZE(256)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .WordCount(WordCount),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write / Done monitor, sampled on the falling edge.
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wcyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          we_double = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (bus.WriteEnable) begin
            wa.push_back(bus.WriteAddress);
            wd.push_back(bus.WriteData);
            wcyc.push_back(cyc);
            if (prev_we) we_double <= we_double + 1;
        end
        prev_we <= bus.WriteEnable;
        if (Done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    logic [7:0] stream[$];
    int         acc_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] wc);
        @(negedge clk);
        Start     = 1'b1;
        WordCount = wc;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Drives every byte of stream; a byte counts as taken when valid and ready overlap at a rising edge.
    task automatic run_stream(input bit throttle, input int budget);
        int idx = 0;
        int n   = 0;
        bit acc = 1'b0;
        bit tog = 1'b0;
        while (1) begin
            @(negedge clk);
            if (acc) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            if (idx >= stream.size()) begin
                bus.ByteValid = 1'b0;
                break;
            end
            if (n >= budget) begin
                bus.ByteValid = 1'b0;
                check("stream_timeout", idx, stream.size());
                break;
            end
            n++;
            tog           = ~tog;
            bus.ByteValid = throttle ? tog : 1'b1;
            bus.ByteIn    = stream[idx];
            acc           = bus.ByteValid && bus.ByteReady;
        end
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == base) check("done_timeout", done_cnt - base, 1);
    endtask

    typedef struct {
        logic [31:0] wc;
        bit          throttle;
        int          nbytes;
        logic [7:0]  b[8];
        int          nwr;
        logic [31:0] w[2];
        bit          exp_err;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bw, bd, nw, seq_bad;
        logic [31:0] e;

        vecs[0].wc = 2;   vecs[0].throttle = 0; vecs[0].nbytes = 8; vecs[0].nwr = 2; vecs[0].exp_err = 0;
        vecs[0].b  = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h22, 8'h00, 8'h08};
        vecs[0].w  = '{32'h8C010004, 32'hAC220008};
        vecs[1]          = vecs[0];
        vecs[1].throttle = 1;
        vecs[2].wc = 0;   vecs[2].throttle = 0; vecs[2].nbytes = 0; vecs[2].nwr = 0; vecs[2].exp_err = 0;
        vecs[2].b  = '{default: 8'h00};
        vecs[2].w  = '{default: 32'h0};
        vecs[3].wc = 257; vecs[3].throttle = 0; vecs[3].nbytes = 0; vecs[3].nwr = 0; vecs[3].exp_err = 1;
        vecs[3].b  = '{default: 8'h00};
        vecs[3].w  = '{default: 32'h0};
        vecs[4].wc = 1;   vecs[4].throttle = 0; vecs[4].nbytes = 4; vecs[4].nwr = 1; vecs[4].exp_err = 0;
        vecs[4].b  = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4].w  = '{32'h00000013, 32'h0};

        reset = 1'b1; Start = 1'b0; WordCount = '0;
        bus.ByteValid = 1'b0; bus.ByteIn = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ByteReady, 0);
        check("rst_we",    bus.WriteEnable, 0);
        check("rst_addr",  bus.WriteAddress, 0);
        check("rst_data",  bus.WriteData, 0);
        check("rst_busy",  Busy, 0);
        check("rst_done",  Done, 0);
        check("rst_error", Error, 0);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            bw = wa.size();
            bd = done_cnt;
            acc_cyc.delete();
            stream.delete();
            for (int i = 0; i < vecs[v].nbytes; i++) stream.push_back(vecs[v].b[i]);
            do_start(vecs[v].wc);
            check($sformatf("v%0d_busy_start", v), Busy, (vecs[v].wc != 0) && !vecs[v].exp_err);
            if (vecs[v].exp_err) begin
                repeat (5) @(negedge clk);
                check($sformatf("v%0d_error", v), Error, 1);
                check($sformatf("v%0d_busy", v), Busy, 0);
                check($sformatf("v%0d_nwr", v), wa.size() - bw, 0);
                check($sformatf("v%0d_done", v), done_cnt - bd, 0);
            end else begin
                run_stream(vecs[v].throttle, 500);
                wait_done(bd, 200);
                repeat (3) @(negedge clk);
                nw = wa.size() - bw;
                check($sformatf("v%0d_nwr", v), nw, vecs[v].nwr);
                for (int i = 0; i < vecs[v].nwr && i < nw; i++) begin
                    check($sformatf("v%0d_addr%0d", v, i), wa[bw+i], i);
                    check($sformatf("v%0d_data%0d", v, i), wd[bw+i], vecs[v].w[i]);
                    if (4*i+3 < acc_cyc.size())
                        check($sformatf("v%0d_lat%0d", v, i), wcyc[bw+i], acc_cyc[4*i+3]);
                end
                check($sformatf("v%0d_done", v), done_cnt - bd, 1);
                if (nw > 0) check($sformatf("v%0d_done_cyc", v), done_cyc, wcyc[wa.size()-1] + 1);
                check($sformatf("v%0d_error", v), Error, 0);
                check($sformatf("v%0d_busy_end", v), Busy, 0);
                check($sformatf("v%0d_we_width", v), we_double, 0);
            end
        end

        // Full memory: 256 words of incrementing bytes.
        bw = wa.size(); bd = done_cnt;
        stream.delete(); acc_cyc.delete();
        for (int i = 0; i < 1024; i++) stream.push_back(8'(i));
        do_start(32'd256);
        run_stream(1'b0, 3000);
        wait_done(bd, 200);
        repeat (3) @(negedge clk);
        nw = wa.size() - bw;
        check("full_nwr", nw, 256);
        seq_bad = 0;
        for (int k = 0; k < 256 && k < nw; k++) begin
            e = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            if (wa[bw+k] !== 32'(k) || wd[bw+k] !== e) seq_bad++;
        end
        check("full_seq", seq_bad, 0);
        if (nw > 0) begin
            check("full_last_addr", wa[wa.size()-1], 32'd255);
            check("full_last_data", wd[wd.size()-1], 32'hFCFDFEFF);
        end
        check("full_done", done_cnt - bd, 1);
        check("full_addr_hold", bus.WriteAddress, 32'd255);

        // Reset after two bytes of word 1.
        bw = wa.size(); bd = done_cnt;
        stream.delete(); acc_cyc.delete();
        stream = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h22};
        do_start(32'd2);
        run_stream(1'b0, 200);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", bus.ByteReady, 0);
        check("mid_rst_addr",  bus.WriteAddress, 0);
        check("mid_rst_data",  bus.WriteData, 0);
        check("mid_rst_busy",  Busy, 0);
        check("mid_rst_we",    bus.WriteEnable, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_nwr", wa.size() - bw, 1);
        check("mid_rst_nodone", done_cnt - bd, 0);
        bw = wa.size(); bd = done_cnt;
        stream.delete();
        stream = '{8'h00, 8'h00, 8'h00, 8'h13};
        do_start(32'd1);
        run_stream(1'b0, 200);
        wait_done(bd, 200);
        repeat (3) @(negedge clk);
        nw = wa.size() - bw;
        check("post_rst_nwr", nw, 1);
        if (nw > 0) begin
            check("post_rst_addr", wa[bw], 0);
            check("post_rst_data", wd[bw], 32'h00000013);
        end

        // Start pulsed during RECV must be ignored.
        bw = wa.size(); bd = done_cnt;
        stream.delete();
        stream = '{8'hDE, 8'hAD};
        do_start(32'd1);
        run_stream(1'b0, 200);
        do_start(32'd5);
        check("busy_start_ready", bus.ByteReady, 1);
        stream.delete();
        stream = '{8'hBE, 8'hEF};
        run_stream(1'b0, 200);
        wait_done(bd, 200);
        repeat (20) @(negedge clk);
        nw = wa.size() - bw;
        check("busy_start_nwr", nw, 1);
        if (nw > 0) check("busy_start_data", wd[bw], 32'hDEADBEEF);
        check("busy_start_done", done_cnt - bd, 1);
        check("busy_start_idle", Busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
- Writer side of the instruction memory. Receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit words.
- Issues one single-cycle write per word into the instruction memory write port, at word addresses 0..WordCount-1.
- Sits between the board-level program source (UART/host bridge) and the instruction memory. Used before the PC is released from reset, replacing the static hex-file preload when a runtime load is needed.

Parameters:
- BITS_SIZE, 32, data word width and width of WriteAddress/WordCount; must be a multiple of 8.
- MEMORY_SIZE, 256, number of words in the instruction memory; upper bound for WordCount.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- WordCount  input  BITS_SIZE  number of words to load; sampled with Start.
- ByteIn  input  8  incoming program byte.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader accepts ByteIn this cycle.
- WriteEnable  output  1  one-cycle write strobe to the instruction memory.
- WriteAddress  output  BITS_SIZE  word index (not byte address) for the write.
- WriteData  output  BITS_SIZE  assembled instruction word.
- Busy  output  1  load in progress (RECV or WRITE).
- Done  output  1  one-cycle pulse when the last word has been written.
- Error  output  1  sticky; set when WordCount > MEMORY_SIZE; cleared by reset or by the next Start.

Behaviour:
- Reset, synchronous, active-high: state=IDLE. All outputs and internal counters are 0 (ByteReady, WriteEnable, WriteAddress, WriteData, Busy, Done, Error). Asserting reset mid-load aborts immediately, discards any partial word, and issues no further writes.
- States: IDLE, RECV, WRITE, DONE.
- IDLE, Start=1:
  - WordCount==0: go to DONE.
  - WordCount>MEMORY_SIZE: Error<=1, stay in IDLE.
  - Otherwise: latch WordCount, word index<=0, byte count<=0, Error<=0, go to RECV.
  - Start is ignored in all other states.
- RECV: ByteReady=1 (combinational from state).
  - A byte transfers when ByteValid && ByteReady.
  - Bytes are big-endian: the first byte goes to bits [31:24], the fourth to [7:0], matching hex-file word order.
  - Bytes are shifted into the assembly register while the byte counter increments 0..3.
  - On the transfer that makes the count 4, go to WRITE.
- WRITE: ByteReady=0, so backpressure holds the source.
  - WriteEnable=1 for exactly this one cycle, with WriteAddress=current word index and WriteData=assembled word.
  - Next state: if index==latched WordCount-1, go to DONE; else increment index, clear byte count, return to RECV.
- DONE: Done=1 for one cycle, then IDLE. WriteAddress holds its last value.
- Busy=1 in RECV and WRITE; 0 otherwise.
- Latency: the 4th byte accepted at edge n gives WriteEnable high in cycle n+1. Minimum 5 cycles per word. The final WRITE cycle is followed by Done the next cycle.
- ByteValid without ByteReady (IDLE/WRITE/DONE) is not consumed; the byte stays pending at the source.
- The word index never wraps, because WordCount ≤ MEMORY_SIZE is enforced at Start.

Decomposition:
- Shared package (loader_pkg):
  - State enum {IDLE, RECV, WRITE, DONE}.
  - BYTES_PER_WORD = BITS_SIZE/8.
  - Byte-counter width constant.
- One sub-module, word_packer:
  - Byte shift register plus byte counter.
  - Ports: clk, reset, clear, shift_en, byte_in, word_out, word_full.
  - Lets the FSM stay a pure control block.

Test Plan:
- Basic load: Start with WordCount=2; bytes 8C,01,00,04,AC,22,00,08 with ByteValid held high -> writes (addr 0, 8C010004) then (addr 1, AC220008); Done pulses once in the cycle after the second WriteEnable; Busy then drops.
- Throttled source: same stream with ByteValid toggling every other cycle -> identical writes and data; no duplicated or lost bytes; WriteEnable never exceeds one cycle per word.
- Bounds: WordCount=0 -> Done pulse with no write. WordCount=257 (MEMORY_SIZE=256) -> Error=1, no writes, Busy stays 0. A following valid Start clears Error.
- Full memory: WordCount=256 with incrementing bytes -> last write at addr 255 = FCFDFEFF; no address wrap; Done asserts.
- Reset mid-word: after 2 bytes of word 1, pulse reset -> all outputs 0 next cycle, no write. A fresh Start with WordCount=1 and bytes 00,00,00,13 -> a single write of addr 0, 00000013.
- Start while Busy: pulse Start with WordCount=5 during RECV of a 1-word load -> ignored; exactly one write; Done once.
